// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: mm:ss BCD stopwatch sequencer (run/pause/lap/clear).
// Ports: clk, reset (sync, active-low), btn_ss/btn_lap/btn_clr levels in;
//   sec_lo/sec_hi/min_lo/min_hi display digits, running, frozen, wrap out.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 100,
    parameter int PRE_W    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       frozen,
    output logic       wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_PAUSE
    } state_e;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       sl_q, sl_d, sh_q, sh_d;
    logic [3:0]       ml_q, ml_d, mh_q, mh_d;
    logic [15:0]      snap_q, snap_d;
    logic             wrap_q, wrap_d;
    logic             ss_q, lap_q, clr_q;

    logic ev_ss, ev_lap, ev_clr;
    logic counting, tick;

    assign ev_ss    = btn_ss  & ~ss_q;
    assign ev_lap   = btn_lap & ~lap_q;
    assign ev_clr   = btn_clr & ~clr_q;
    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sl_d    = sl_q;
        sh_d    = sh_q;
        ml_d    = ml_q;
        mh_d    = mh_q;
        snap_d  = snap_q;
        wrap_d  = 1'b0;

        if (counting) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end

        // Carry chain; >= compares keep a corrupted digit from escaping its range.
        if (tick) begin
            if (sl_q >= 4'd9) begin
                sl_d = 4'd0;
                if (sh_q >= 4'd5) begin
                    sh_d = 4'd0;
                    if (ml_q >= 4'd9) begin
                        ml_d = 4'd0;
                        if (mh_q >= 4'd5) begin
                            mh_d   = 4'd0;
                            wrap_d = 1'b1;
                        end else begin
                            mh_d = mh_q + 4'd1;
                        end
                    end else begin
                        ml_d = ml_q + 4'd1;
                    end
                end else begin
                    sh_d = sh_q + 4'd1;
                end
            end else begin
                sl_d = sl_q + 4'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (ev_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (ev_ss) begin
                    state_d = S_PAUSE;
                end else if (ev_lap) begin
                    state_d = S_LAP;
                    // Snapshot takes the pre-increment value.
                    snap_d  = {mh_q, ml_q, sh_q, sl_q};
                end
            end
            S_LAP: begin
                if (ev_ss) begin
                    state_d = S_PAUSE;
                end else if (ev_lap) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    sl_d    = 4'd0;
                    sh_d    = 4'd0;
                    ml_d    = 4'd0;
                    mh_d    = 4'd0;
                end else if (ev_ss) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            sl_q    <= 4'd0;
            sh_q    <= 4'd0;
            ml_q    <= 4'd0;
            mh_q    <= 4'd0;
            snap_q  <= 16'd0;
            wrap_q  <= 1'b0;
            // Held buttons across reset release must not register a press.
            ss_q    <= 1'b1;
            lap_q   <= 1'b1;
            clr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sl_q    <= sl_d;
            sh_q    <= sh_d;
            ml_q    <= ml_d;
            mh_q    <= mh_d;
            snap_q  <= snap_d;
            wrap_q  <= wrap_d;
            ss_q    <= btn_ss;
            lap_q   <= btn_lap;
            clr_q   <= btn_clr;
        end
    end

    always_comb begin
        if (state_q == S_LAP) begin
            {min_hi, min_lo, sec_hi, sec_lo} = snap_q;
        end else begin
            {min_hi, min_lo, sec_hi, sec_lo} = {mh_q, ml_q, sh_q, sl_q};
        end
    end

    assign running = counting;
    assign frozen  = (state_q == S_LAP);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: scoreboard bench for bcd_stopwatch_ctrl.
// Model keeps elapsed time as a plain seconds count 0..3599.
module tb_bcd_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_ss = 1'b1;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic       running, frozen, wrap;

    bcd_stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
        .clk(clk), .reset(reset),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .sec_lo(sec_lo), .sec_hi(sec_hi),
        .min_lo(min_lo), .min_hi(min_hi),
        .running(running), .frozen(frozen), .wrap(wrap)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    int  m_mode, m_cnt, m_snap, m_pre, m_wraps;
    bit  m_wrap, h_ss, h_lap, h_clr;
    int  checks = 0, errors = 0, dut_wraps = 0;
    bit  started = 0, done = 0;
    logic [18:0] exp_q[$];

    function automatic logic [15:0] to_bcd(input int v);
        int m, s;
        m = v / 60;
        s = v % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model(input bit r, input bit s, input bit l, input bit c);
        bit es, el, ec, cnt_on, tk;
        if (!r) begin
            m_mode = M_IDLE; m_cnt = 0; m_snap = 0; m_pre = 0;
            m_wrap = 0; h_ss = 1; h_lap = 1; h_clr = 1;
            return;
        end
        es = s && !h_ss;
        el = l && !h_lap;
        ec = c && !h_clr;
        h_ss = s; h_lap = l; h_clr = c;
        cnt_on = (m_mode == M_RUN) || (m_mode == M_LAP);
        tk = cnt_on && (m_pre == TD - 1);
        m_wrap = tk && (m_cnt == 3599);
        if (m_wrap) m_wraps++;
        if (cnt_on) m_pre = tk ? 0 : m_pre + 1;
        case (m_mode)
            M_IDLE: if (es) m_mode = M_RUN;
            M_RUN: begin
                if (es) m_mode = M_PAUSE;
                else if (el) begin
                    m_mode = M_LAP;
                    m_snap = m_cnt;
                end
            end
            M_LAP: begin
                if (es) m_mode = M_PAUSE;
                else if (el) m_mode = M_RUN;
            end
            default: begin
                if (ec) begin
                    m_mode = M_IDLE; m_cnt = 0; m_pre = 0;
                end else if (es) m_mode = M_RUN;
            end
        endcase
        if (tk) m_cnt = (m_cnt + 1) % 3600;
    endtask

    task automatic step(input bit r, input bit s, input bit l, input bit c);
        @(negedge clk);
        reset = r; btn_ss = s; btn_lap = l; btn_clr = c;
        model(r, s, l, c);
        exp_q.push_back({to_bcd(m_mode == M_LAP ? m_snap : m_cnt),
                         (m_mode == M_RUN) || (m_mode == M_LAP),
                         m_mode == M_LAP, m_wrap});
        started = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    task automatic press(input bit s, input bit l, input bit c);
        step(1, s, l, c);
        step(1, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge after stimulus starts.
    initial begin
        logic [18:0] e, a;
        while (!done) begin
            @(posedge clk);
            #1;
            if (started && !done) begin
                a = {min_hi, min_lo, sec_hi, sec_lo, running, frozen, wrap};
                if (wrap) dut_wraps++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got %h", $time, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL out t=%0t got mm:ss=%h run=%b frz=%b wrap=%b want mm:ss=%h run=%b frz=%b wrap=%b",
                                 $time, a[18:3], a[2], a[1], a[0],
                                 e[18:3], e[2], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        m_wraps = 0;
        // Reset with start held, then release: no start expected.
        repeat (3) step(0, 1, 0, 0);
        repeat (5) step(1, 1, 0, 0);
        idle(3);
        // Start and hold: 160 cycles -> 00:40.
        repeat (160) step(1, 1, 0, 0);
        // Run through 59:58, 59:59 and the wrap.
        idle(14300);
        // Lap freeze and release.
        idle(20);
        press(0, 1, 0);
        idle(30);
        press(0, 1, 0);
        idle(10);
        // Pause, hold, clear+start together, restart, clr in RUN ignored.
        press(1, 0, 0);
        idle(100);
        press(1, 0, 1);
        idle(5);
        press(1, 0, 0);
        idle(20);
        press(0, 0, 1);
        idle(20);
        // Lap and start together: start wins.
        press(1, 1, 0);
        idle(8);
        press(1, 0, 0);
        idle(3000);
        // Reset for one edge while running.
        step(0, 0, 0, 0);
        idle(5);
        // Random phase.
        for (int i = 0; i < 20000; i++) begin
            bit r, s, l, c;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 5) == 0) ? ~btn_ss : btn_ss;
            l = ($urandom_range(0, 5) == 0) ? ~btn_lap : btn_lap;
            c = ($urandom_range(0, 7) == 0) ? ~btn_clr : btn_clr;
            step(r, s, l, c);
        end
        @(posedge clk);
        #2;
        done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        checks++;
        if (dut_wraps != m_wraps) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", dut_wraps, m_wraps);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
